fifo_rr_pop_arbiter: RTL and testbench

//  Downstream consumer of NUM_CH parallel FIFOs. Round-robin pops one word per cycle from non-empty FIFOs.

---
 rtl/fifo_rr_pop_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fifo_rr_pop_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_pop_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_pop_arbiter
//
// Purpose:
//   Drains NUM_CH parallel source FIFOs one word per cycle using round-robin
//   arbitration. Each word is forwarded downstream tagged with the channel it
//   came from. Popping stops while the downstream stage reports almost-full
//   (dn_pause) or while enable is low. A word already popped is always
//   delivered.
//
//   The source FIFOs sample their read strobe at the clock edge and present
//   the popped word on buff_out one cycle later. Their empty flag also lags
//   by one cycle, so the channel popped in the previous cycle is never
//   eligible.
//
// Optional feature (macro ARB_URGENT_PRIO_EN):
//   Adds input fifo_almost_full. Eligible channels whose source FIFO is
//   almost full win over all other eligible channels. Round-robin order
//   from rr_ptr is applied inside whichever set is chosen.
//
// Ports:
//   clk              in   clock; all state changes on posedge
//   reset_L          in   asynchronous reset, active high
//   fifo_empty       in   per-channel empty flag from the source FIFOs
//   fifo_data        in   per-channel buff_out; ch i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_almost_full in   per-channel almost-full (ARB_URGENT_PRIO_EN only)
//   dn_pause         in   downstream almost-full; 1 = stop popping
//   enable           in   0 = no new pops; an in-flight word still completes
//   fifo_pop         out  one-hot read strobe to the source FIFOs
//   out_valid        out  one-cycle pulse per forwarded word
//   out_data         out  forwarded word (holds when out_valid=0)
//   out_ch           out  source channel of out_data (holds when out_valid=0)
//   fwd_count        out  words forwarded since reset, wraps
//   busy             out  FSM is not in IDLE
// ---------------------------------------------------------------------------
module fifo_rr_pop_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset_L,
    input  logic [NUM_CH-1:0]            fifo_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data,
`ifdef ARB_URGENT_PRIO_EN
    input  logic [NUM_CH-1:0]            fifo_almost_full,
`endif
    input  logic                         dn_pause,
    input  logic                         enable,
    output logic [NUM_CH-1:0]            fifo_pop,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(NUM_CH)-1:0]    out_ch,
    output logic [CNT_WIDTH-1:0]         fwd_count,
    output logic                         busy
);

    localparam int              CH_W   = $clog2(NUM_CH);
    localparam logic [CH_W-1:0] CH_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   r_pop_ch_q;
    logic              r_pop_vld_q;

    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_cand;
    logic              w_any_elig;
    logic              w_any_ready;
    logic              w_grant_found;
    logic [CH_W-1:0]   w_grant_ch;
    logic              w_do_pop;

    // A channel popped last cycle still shows non-empty because of the flag
    // lag, so it sits out one cycle.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
            assign w_elig[gi] = !fifo_empty[gi] &&
                                !(r_pop_vld_q && (r_pop_ch_q == CH_W'(gi)));
        end
    endgenerate

`ifdef ARB_URGENT_PRIO_EN
    logic [NUM_CH-1:0] w_urgent;
    assign w_urgent = w_elig & fifo_almost_full;
    assign w_cand   = (|w_urgent) ? w_urgent : w_elig;
`else
    assign w_cand   = w_elig;
`endif

    assign w_any_elig  = |w_elig;
    assign w_any_ready = |(~fifo_empty);

    // First candidate at or after rr_ptr. Scanning downwards lets the
    // smallest offset win without an early exit.
    always_comb begin
        logic [CH_W-1:0] w_idx;
        w_grant_found = 1'b0;
        w_grant_ch    = '0;
        w_idx         = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = r_rr_ptr + CH_W'(k);
            if (w_cand[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_ch    = w_idx;
            end
        end
    end

    // The strobe is decoded from registered state plus the current flags so
    // that a pause or an empty flag seen this cycle blocks the pop this cycle.
    // The granted channel is captured into r_pop_ch_q/r_pop_vld_q.
    assign w_do_pop = (r_state == ST_ACTIVE) && enable && !dn_pause && w_grant_found;

    always_comb begin
        fifo_pop = '0;
        if (w_do_pop) begin
            fifo_pop[w_grant_ch] = 1'b1;
        end
    end

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_pop_ch_q  <= '0;
            r_pop_vld_q <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ch      <= '0;
            fwd_count   <= '0;
        end else begin
            r_pop_vld_q <= w_do_pop;
            if (w_do_pop) begin
                r_pop_ch_q <= w_grant_ch;
                r_rr_ptr   <= w_grant_ch + CH_ONE;
            end

            // Source buff_out is valid the cycle after the pop.
            out_valid <= r_pop_vld_q;
            if (r_pop_vld_q) begin
                out_data  <= fifo_data[r_pop_ch_q*DATA_WIDTH +: DATA_WIDTH];
                out_ch    <= r_pop_ch_q;
                fwd_count <= fwd_count + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable && !dn_pause && w_any_elig) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (dn_pause) begin
                        r_state <= ST_STALL;
                    end else if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (!w_any_elig && !w_any_ready) begin
                        r_state <= ST_IDLE;
                    end
                    // Non-empty but nothing eligible means only the channel
                    // popped last cycle has data; holding ACTIVE lets a lone
                    // channel stream every other cycle.
                end
                ST_STALL: begin
                    if (!dn_pause) begin
                        r_state <= (enable && w_any_elig) ? ST_ACTIVE : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_pop_arbiter.sv
module tb_fifo_rr_pop_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 6;
    localparam int CW  = 8;

    logic              clk = 1'b0;
    logic              reset_L;
    logic [NCH-1:0]    fifo_empty;
    logic [NCH*DW-1:0] fifo_data;
    logic              dn_pause;
    logic              enable;
    logic [NCH-1:0]    fifo_pop;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_ch;
    logic [CW-1:0]     fwd_count;
    logic              busy;
`ifdef ARB_URGENT_PRIO_EN
    logic [NCH-1:0]    fifo_almost_full;
`endif

    always #5 clk = ~clk;

    fifo_rr_pop_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .fifo_empty       (fifo_empty),
        .fifo_data        (fifo_data),
`ifdef ARB_URGENT_PRIO_EN
        .fifo_almost_full (fifo_almost_full),
`endif
        .dn_pause         (dn_pause),
        .enable           (enable),
        .fifo_pop         (fifo_pop),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ch           (out_ch),
        .fwd_count        (fwd_count),
        .busy             (busy)
    );

    // Source FIFO model: queue contents, registered buff_out, lagged empty flag.
    typedef logic [DW-1:0] word_q_t[$];
    word_q_t        src_q [NCH];
    logic [DW-1:0]  buff [NCH];
    logic [NCH-1:0] empty_vis;

    assign fifo_empty = empty_vis;
    assign fifo_data  = {buff[3], buff[2], buff[1], buff[0]};

    typedef struct {
        logic [1:0]    ch;
        logic [DW-1:0] data;
        int            cyc;
    } sb_t;
    sb_t sb[$];

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [DW-1:0] seq_data = '0;

    logic [NCH-1:0] s_pop;
    logic           s_ov;
    logic           s_busy;
    logic [1:0]     s_ch;
    logic [DW-1:0]  s_data;
    logic [CW-1:0]  s_cnt;

    task automatic push_word(input int ch);
        src_q[ch].push_back(seq_data);
        seq_data = seq_data + 1'b1;
    endtask

    task automatic assert_reset();
        reset_L = 1'b1;
        sb.delete();
        exp_cnt = '0;
    endtask

    // One clock: sample/check at negedge, then advance the source model.
    task automatic cycle();
        sb_t e;
        int  ch;
        logic prev_empty;
        @(negedge clk);
        cyc++;
        s_pop  = fifo_pop;
        s_ov   = out_valid;
        s_busy = busy;
        s_ch   = out_ch;
        s_data = out_data;
        s_cnt  = fwd_count;
        if (s_pop != '0) begin
            checks++;
            if (($countones(s_pop) != 1) || ((s_pop & empty_vis) != '0)) begin
                errors++;
                $display("FAIL pop_legal cyc=%0d fifo_pop=%b empty=%b (need one-hot on non-empty)",
                         cyc, s_pop, empty_vis);
            end
            ch = 0;
            for (int i = 0; i < NCH; i++) if (s_pop[i]) ch = i;
            if (src_q[ch].size() == 0) begin
                errors++;
                $display("FAIL pop_underflow cyc=%0d ch=%0d popped with no data", cyc, ch);
            end else begin
                e.ch = 2'(ch); e.data = src_q[ch][0]; e.cyc = cyc;
                sb.push_back(e);
            end
        end
        if (s_ov) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stray_out cyc=%0d ch=%0d data=%0d with nothing expected", cyc, s_ch, s_data);
            end else begin
                e = sb.pop_front();
                exp_cnt = exp_cnt + 1'b1;
                if (s_ch !== e.ch || s_data !== e.data || cyc != e.cyc + 2 || s_cnt !== exp_cnt) begin
                    errors++;
                    $display("FAIL out_word cyc=%0d ch=%0d/%0d data=%0d/%0d pop_cyc=%0d cnt=%0d/%0d (got/need)",
                             cyc, s_ch, e.ch, s_data, e.data, e.cyc, s_cnt, exp_cnt);
                end
            end
        end else if (sb.size() != 0 && cyc >= sb[0].cyc + 2) begin
            checks++;
            errors++;
            $display("FAIL missing_out cyc=%0d word from pop at cyc %0d not delivered", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            prev_empty = (src_q[i].size() == 0);
            if (s_pop[i] && src_q[i].size() != 0) buff[i] = src_q[i].pop_front();
            empty_vis[i] = prev_empty;
        end
    endtask

    task automatic wait_first_pop(input string name);
        bit found = 0;
        for (int n = 0; n < 12 && !found; n++) begin
            cycle();
            if (s_pop != '0) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_timeout no pop within 12 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        bit done = 0;
        enable   = 1'b1;
        dn_pause = 1'b0;
        for (int n = 0; n < 700 && !done; n++) begin
            cycle();
            done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (src_q[2].size() == 0) &&
                   (src_q[3].size() == 0) && (sb.size() == 0) && !s_busy;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain_timeout busy=%0b pending=%0d", name, s_busy, sb.size());
        end
    endtask

    task automatic test_reset();
        assert_reset();
        enable = 1'b0; dn_pause = 1'b0;
        cycle(); cycle();
        checks++;
        if (s_pop !== '0 || s_ov !== 1'b0 || s_cnt !== '0 || s_busy !== 1'b0 ||
            s_data !== '0 || s_ch !== '0) begin
            errors++;
            $display("FAIL reset_state pop=%b ov=%b cnt=%0d busy=%b data=%0d ch=%0d (need all 0)",
                     s_pop, s_ov, s_cnt, s_busy, s_data, s_ch);
        end
        reset_L = 1'b0;
    endtask

    task automatic test_rr();
        logic [NCH-1:0] exp_pop;
        for (int c = 0; c < NCH; c++) for (int w = 0; w < 6; w++) push_word(c);
        enable = 1'b1;
        wait_first_pop("rr");
        checks++;
        if (s_pop !== 4'b0001) begin
            errors++;
            $display("FAIL rr_first fifo_pop=%b need 0001", s_pop);
        end
        for (int k = 1; k < 8; k++) begin
            cycle();
            exp_pop = 4'b0001 << (k % 4);
            checks++;
            if (s_pop !== exp_pop) begin
                errors++;
                $display("FAIL rr_seq k=%0d fifo_pop=%b need %b", k, s_pop, exp_pop);
            end
            if (k >= 2) begin
                checks++;
                if (s_ov !== 1'b1 || s_ch !== 2'((k - 2) % 4)) begin
                    errors++;
                    $display("FAIL rr_out_ch k=%0d ov=%b ch=%0d need ov=1 ch=%0d", k, s_ov, s_ch, (k - 2) % 4);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        assert_reset();
        cycle();
        checks++;
        if (s_pop !== '0 || s_ov !== 1'b0 || s_cnt !== '0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid pop=%b ov=%b cnt=%0d busy=%b (need 0)", s_pop, s_ov, s_cnt, s_busy);
        end
        enable  = 1'b0;
        reset_L = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks++;
            if (s_ov !== 1'b0 || s_pop !== '0) begin
                errors++;
                $display("FAIL reset_release n=%0d ov=%b pop=%b (need 0)", n, s_ov, s_pop);
            end
        end
        enable = 1'b1;
        wait_first_pop("post_reset");
        checks++;
        if (s_pop !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_ptr fifo_pop=%b need 0001", s_pop);
        end
        drain("reset_mid");
    endtask

    task automatic test_single();
        int pc[$];
        int nouts = 0;
        for (int w = 0; w < 3; w++) push_word(2);
        enable = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (s_ov) nouts++;
            if (s_pop != '0) begin
                pc.push_back(cyc);
                checks++;
                if (s_pop !== 4'b0100) begin
                    errors++;
                    $display("FAIL single_ch fifo_pop=%b need 0100", s_pop);
                end
            end
        end
        checks++;
        if (pc.size() != 3 || nouts != 3 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_count pops=%0d outs=%0d busy=%b need 3 3 0", pc.size(), nouts, s_busy);
        end else begin
            checks++;
            if (pc[1] - pc[0] != 2 || pc[2] - pc[1] != 2) begin
                errors++;
                $display("FAIL single_spacing gaps=%0d,%0d need 2,2", pc[1] - pc[0], pc[2] - pc[1]);
            end
        end
    endtask

    task automatic test_pause();
        int last = 0;
        int nouts = 0;
        logic [NCH-1:0] exp_pop;
        for (int c = 0; c < NCH; c++) for (int w = 0; w < 4; w++) push_word(c);
        enable = 1'b1;
        wait_first_pop("pause");
        cycle();
        checks++;
        if (s_pop == '0) begin
            errors++;
            $display("FAIL pause_second_pop fifo_pop=%b need a pop", s_pop);
        end
        for (int i = 0; i < NCH; i++) if (s_pop[i]) last = i;
        dn_pause = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cycle();
            if (s_ov) nouts++;
            checks++;
            if (s_pop !== '0 || s_busy !== 1'b1) begin
                errors++;
                $display("FAIL pause_stall n=%0d pop=%b busy=%b need pop=0 busy=1", n, s_pop, s_busy);
            end
        end
        checks++;
        if (nouts != 2) begin
            errors++;
            $display("FAIL pause_inflight outs=%0d need 2", nouts);
        end
        dn_pause = 1'b0;
        cycle();
        checks++;
        if (s_pop !== '0) begin
            errors++;
            $display("FAIL pause_exit pop=%b need 0", s_pop);
        end
        cycle();
        exp_pop = 4'b0001 << ((last + 1) % 4);
        checks++;
        if (s_pop !== exp_pop) begin
            errors++;
            $display("FAIL pause_resume pop=%b need %b", s_pop, exp_pop);
        end
        drain("pause");
    endtask

    task automatic test_wrap();
        int  need;
        bit  saw = 0;
        logic [CW-1:0] prev;
        need = 256 - int'(exp_cnt);
        for (int w = 0; w < need; w++) push_word(w % NCH);
        enable = 1'b1;
        for (int n = 0; n < 600 && !saw; n++) begin
            prev = exp_cnt;
            cycle();
            if (s_ov && prev == 8'd255) begin
                saw = 1;
                checks++;
                if (s_cnt !== '0) begin
                    errors++;
                    $display("FAIL wrap fwd_count=%0d need 0", s_cnt);
                end
            end
        end
        checks++;
        if (!saw) begin
            errors++;
            $display("FAIL wrap_timeout count stuck at %0d", exp_cnt);
        end
        drain("wrap");
    endtask

`ifdef ARB_URGENT_PRIO_EN
    task automatic test_urgent();
        assert_reset();
        cycle();
        reset_L = 1'b0;
        fifo_almost_full = 4'b1000;
        for (int w = 0; w < 2; w++) begin
            push_word(0); push_word(1); push_word(3);
        end
        enable = 1'b1;
        wait_first_pop("urgent");
        checks++;
        if (s_pop !== 4'b1000) begin
            errors++;
            $display("FAIL urgent_first pop=%b need 1000", s_pop);
        end
        cycle();
        checks++;
        if (s_pop !== 4'b0001) begin
            errors++;
            $display("FAIL urgent_second pop=%b need 0001", s_pop);
        end
        fifo_almost_full = '0;
        drain("urgent");
    endtask
`endif

    initial begin
        reset_L   = 1'b1;
        enable    = 1'b0;
        dn_pause  = 1'b0;
        empty_vis = '1;
        for (int i = 0; i < NCH; i++) buff[i] = '0;
`ifdef ARB_URGENT_PRIO_EN
        fifo_almost_full = '0;
`endif
        test_reset();
        test_rr();
        test_reset_mid();
        test_single();
        test_pause();
        test_wrap();
`ifdef ARB_URGENT_PRIO_EN
        test_urgent();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
